spi_slave: RTL and testbench

Byte-oriented SPI slave in the system clock domain. It oversamples the external SPI pins (spi_sclk, spi_cs_n, spi_mosi) and drives spi_miso. It exposes the same valid/ready byte interface as the team's SPI master, so a board-level master can exchange full-duplex bytes with on-chip logic. It is the receiving end of the master's link and also the loopback partner for master verification.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 145 ++++++++++++++
 tb/tb_spi_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decoding, byte geometry and the underrun fill byte.
// Imported by the SPI slave and available to the SPI master.
package spi_pkg;

    localparam int SPI_BYTE_BITS = 8;
    localparam logic [SPI_BYTE_BITS-1:0] SPI_IDLE_FILL = 8'hFF;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

    function automatic spi_mode_t spi_decode_mode(input int mode);
        logic [1:0] m;
        m = mode[1:0];
        return '{cpol: m[1], cpha: m[0]};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
// Pulses appear SYNC_STAGES+1 clk cycles after the pin transition.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            prev <= RESET_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
            fall <= ~sync[SYNC_STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// Oversampling byte-oriented SPI slave with a one-byte TX holding buffer.
// Define SPI_SLAVE_STATUS_EN to add status_clr, tx_underrun and frame_abort.
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
`ifdef SPI_SLAVE_STATUS_EN
    input  logic       status_clr,
    output logic       tx_underrun,
    output logic       frame_abort,
`endif
    output logic       spi_miso
);

    localparam spi_mode_t MODE_CFG = spi_decode_mode(SPI_MODE);
    localparam logic CPOL = MODE_CFG.cpol;
    localparam logic CPHA = MODE_CFG.cpha;
    localparam int CNT_W = $clog2(SPI_BYTE_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BYTE_BITS - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // MOSI gets the same depth so it stays aligned with the SCLK edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end

    spi_state_t                   state;
    logic [CNT_W-1:0]             bit_cnt;
    logic [SPI_BYTE_BITS-2:0]     rx_shift;
    logic [SPI_BYTE_BITS-1:0]     tx_shift;
    logic [SPI_BYTE_BITS-1:0]     buf_data;
    logic                         buf_full;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic entry, leave, edge_ok, load, wr;
    logic [SPI_BYTE_BITS-1:0] load_byte, rx_next;

    always_comb begin
        lead_edge   = CPOL ? sclk_fall : sclk_rise;
        trail_edge  = CPOL ? sclk_rise : sclk_fall;
        sample_edge = CPHA ? trail_edge : lead_edge;
        shift_edge  = CPHA ? lead_edge : trail_edge;
        entry       = (state == SPI_IDLE) && cs_fall;
        leave       = (state == SPI_ACTIVE) && cs_rise;
        edge_ok     = (state == SPI_ACTIVE) && !cs_rise;
        // A shift edge at count 0 is the first of a byte (CPHA=1) or the one after the 8th sample (CPHA=0)
        load        = (entry && !CPHA) || (edge_ok && shift_edge && (bit_cnt == '0));
        wr          = tx_valid && !buf_full;
        load_byte   = buf_full ? buf_data : SPI_IDLE_FILL;
        rx_next     = {rx_shift, mosi_sync[SYNC_STAGES-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SPI_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            buf_data <= '0;
            buf_full <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;

            if (wr) begin
                buf_data <= tx_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (load)
                tx_shift <= load_byte;
            else if (edge_ok && shift_edge)
                tx_shift <= {tx_shift[SPI_BYTE_BITS-2:0], 1'b0};

            if (entry)
                state <= SPI_ACTIVE;

            if (leave) begin
                state    <= SPI_IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
            end else if (edge_ok && sample_edge) begin
                rx_shift <= rx_next[SPI_BYTE_BITS-2:0];
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_underrun <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            if (load && !buf_full)  tx_underrun <= 1'b1;
            else if (status_clr)    tx_underrun <= 1'b0;
            if (leave && (bit_cnt != '0)) frame_abort <= 1'b1;
            else if (status_clr)          frame_abort <= 1'b0;
        end
    end
`endif

    assign tx_ready = ~buf_full;
    assign spi_miso = tx_shift[SPI_BYTE_BITS-1];

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: one instance per SPI mode driven by a behavioural master.
// Status-flag checks are included when SPI_SLAVE_STATUS_EN is defined.
module tb_spi_slave;

    localparam int SS       = 2;
    localparam int HALF     = SS + 4;
    localparam int WATCHDOG = 500000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [3:0][7:0] tx_data, rx_data;
    logic [3:0]      tx_valid, tx_ready, rx_valid, sclk, cs_n, mosi, miso;
`ifdef SPI_SLAVE_STATUS_EN
    logic [3:0]      status_clr, tx_underrun, frame_abort;
`endif

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            spi_slave #(.SPI_MODE(g), .SYNC_STAGES(SS)) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .tx_data    (tx_data[g]),
                .tx_valid   (tx_valid[g]),
                .tx_ready   (tx_ready[g]),
                .rx_data    (rx_data[g]),
                .rx_valid   (rx_valid[g]),
                .spi_sclk   (sclk[g]),
                .spi_cs_n   (cs_n[g]),
                .spi_mosi   (mosi[g]),
`ifdef SPI_SLAVE_STATUS_EN
                .status_clr (status_clr[g]),
                .tx_underrun(tx_underrun[g]),
                .frame_abort(frame_abort[g]),
`endif
                .spi_miso   (miso[g])
            );
        end
    endgenerate

    int n_cmp  = 0;
    int n_fail = 0;
    logic [11:0] exp_rx_q[$];   // {instance, byte} expected on rx_valid
    logic [7:0]  exp_miso_q[$]; // bytes the master expects on MISO

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        logic [11:0] e;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (rx_valid[m]) begin
                    if (exp_rx_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL rx_unexpected: inst %0d got %0h expected no rx_valid", m, rx_data[m]);
                    end else begin
                        e = exp_rx_q.pop_front();
                        check("rx_byte", 32'({m[3:0], rx_data[m]}), 32'(e));
                    end
                end
            end
        end
    endtask

    task automatic tx_write(input int m, input logic [7:0] d);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
    endtask

    task automatic feed(input int m, input logic [7:0] d);
        for (int c = 0; c < 2000 && !tx_ready[m]; c++) @(negedge clk);
        check("feed_ready", 32'(tx_ready[m]), 32'd1);
        tx_write(m, d);
    endtask

    // Behavioural master; a short last byte is not checked on MISO
    task automatic spi_frame(input int m, input int nbytes, input logic [7:0] b0,
                             input logic [7:0] b1, input int last_bits, input bit end_cs);
        logic cpol, cpha;
        logic [7:0] tx, rx, e;
        int nb;
        cpol = m[1];
        cpha = m[0];
        cs_n[m] = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < nbytes; k++) begin
            tx = (k == 0) ? b0 : b1;
            nb = (k == nbytes - 1) ? last_bits : 8;
            rx = 8'h00;
            for (int i = 7; i >= 8 - nb; i--) begin
                if (!cpha) begin
                    mosi[m] = tx[i];
                    wait_clk(HALF);
                    sclk[m] = ~cpol;
                    rx[i]   = miso[m];
                    wait_clk(HALF);
                    sclk[m] = cpol;
                end else begin
                    sclk[m] = ~cpol;
                    mosi[m] = tx[i];
                    wait_clk(HALF);
                    sclk[m] = cpol;
                    rx[i]   = miso[m];
                    wait_clk(HALF);
                end
            end
            if (nb == 8) begin
                e = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 8'hxx;
                check("miso_byte", 32'(rx), 32'(e));
            end
        end
        if (end_cs) begin
            wait_clk(HALF);
            cs_n[m] = 1'b1;
            mosi[m] = 1'b0;
            wait_clk(HALF);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        fork
            begin
                #(WATCHDOG);
                $display("FAIL watchdog: time limit reached before summary");
                $fatal(1, "watchdog");
            end
        join_none

        rst_n    = 1'b0;
        sclk     = 4'b1100;
        cs_n     = 4'hF;
        mosi     = 4'h0;
        tx_valid = 4'h0;
        tx_data  = '0;
`ifdef SPI_SLAVE_STATUS_EN
        status_clr = 4'h0;
`endif
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);

        // Reset state on every instance
        for (int m = 0; m < 4; m++) begin
            check("rst_tx_ready", 32'(tx_ready[m]), 32'd1);
            check("rst_rx_valid", 32'(rx_valid[m]), 32'd0);
            check("rst_rx_data",  32'(rx_data[m]),  32'd0);
            check("rst_miso",     32'(miso[m]),     32'd0);
        end

        // Mode 0 single exchange: A5 in, 3C out
        tx_write(0, 8'h3C);
        check("m0_tx_ready_busy", 32'(tx_ready[0]), 32'd0);
        exp_rx_q.push_back({4'd0, 8'hA5});
        exp_miso_q.push_back(8'h3C);
        spi_frame(0, 1, 8'hA5, 8'h00, 8, 1'b1);
        check("m0_tx_ready_free", 32'(tx_ready[0]), 32'd1);

        // Modes 1..3: back-to-back 01, 80 in both directions
        for (int m = 1; m < 4; m++) begin
            tx_write(m, 8'h01);
            exp_rx_q.push_back({4'(m), 8'h01});
            exp_rx_q.push_back({4'(m), 8'h80});
            exp_miso_q.push_back(8'h01);
            exp_miso_q.push_back(8'h80);
            fork
                spi_frame(m, 2, 8'h01, 8'h80, 8, 1'b1);
                feed(m, 8'h80);
            join
        end

        // Underrun: empty buffer at cs_n fall sends the idle fill
`ifdef SPI_SLAVE_STATUS_EN
        status_clr[0] = 1'b1;
        wait_clk(1);
        status_clr[0] = 1'b0;
        check("underrun_cleared", 32'(tx_underrun[0]), 32'd0);
`endif
        exp_rx_q.push_back({4'd0, 8'hC3});
        exp_miso_q.push_back(8'hFF);
        spi_frame(0, 1, 8'hC3, 8'h00, 8, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
        check("underrun_set", 32'(tx_underrun[0]), 32'd1);
        status_clr[0] = 1'b1;
        wait_clk(1);
        status_clr[0] = 1'b0;
        check("underrun_clr", 32'(tx_underrun[0]), 32'd0);
        check("abort_clr", 32'(frame_abort[0]), 32'd0);
`endif

        // Abort after 5 bits, then a clean 5A
        spi_frame(0, 1, 8'hFF, 8'h00, 5, 1'b1);
`ifdef SPI_SLAVE_STATUS_EN
        check("abort_set", 32'(frame_abort[0]), 32'd1);
`endif
        exp_rx_q.push_back({4'd0, 8'h5A});
        exp_miso_q.push_back(8'hFF);
        spi_frame(0, 1, 8'h5A, 8'h00, 8, 1'b1);
        check("abort_rx_data", 32'(rx_data[0]), 32'h5A);

        // Write lands in the same cycle as the cs_n-entry load
        exp_rx_q.push_back({4'd0, 8'h24});
        exp_rx_q.push_back({4'd0, 8'h42});
        exp_miso_q.push_back(8'hFF);
        exp_miso_q.push_back(8'h7E);
        fork
            spi_frame(0, 2, 8'h24, 8'h42, 8, 1'b1);
            begin
                wait_clk(SS + 1);
                tx_data[0]  = 8'h7E;
                tx_valid[0] = 1'b1;
                @(negedge clk);
                tx_valid[0] = 1'b0;
                check("collide_ready", 32'(tx_ready[0]), 32'd0);
                wait_clk(HALF);
                check("collide_ready_hold", 32'(tx_ready[0]), 32'd0);
            end
        join

        // Reset mid-byte with a byte pending in the buffer
        spi_frame(0, 1, 8'hF0, 8'h00, 4, 1'b0);
        tx_write(0, 8'h33);
        check("pre_rst_ready", 32'(tx_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
        check("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        check("mid_rst_rx_data",  32'(rx_data[0]),  32'd0);
        check("mid_rst_miso",     32'(miso[0]),     32'd0);
`ifdef SPI_SLAVE_STATUS_EN
        check("mid_rst_underrun", 32'(tx_underrun[0]), 32'd0);
        check("mid_rst_abort",    32'(frame_abort[0]), 32'd0);
`endif
        cs_n[0] = 1'b1;
        mosi[0] = 1'b0;
        wait_clk(SS + 3);
        rst_n = 1'b1;
        wait_clk(2);
        tx_write(0, 8'h69);
        exp_rx_q.push_back({4'd0, 8'h96});
        exp_miso_q.push_back(8'h69);
        spi_frame(0, 1, 8'h96, 8'h00, 8, 1'b1);
        check("post_rst_rx_data", 32'(rx_data[0]), 32'h96);

        wait_clk(10);
        check("rx_queue_drained",   32'(exp_rx_q.size()),   32'd0);
        check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
